// File: rtl/regdecr_valrdy_pipe.sv
// regdecr_valrdy_pipe
//
// Elastic pipelined registered decrementer with val/rdy handshakes on both
// sides. It is the return-path partner of the registered incrementer: the
// stages store the raw incoming message, and the decrement is applied on
// the way out of the last stage. This restores the value the incrementer
// started from.
//
// Each stage is a valid bit plus a data word. A stage can take a new
// message when it is empty or when its own content is leaving in the same
// cycle. Because of this, messages move up into empty slots while the
// output is stalled, and the pipeline still accepts one message per cycle
// when out_rdy stays high.
//
// Parameters:
//   p_nbits    - message width in bits
//   p_nstages  - number of pipeline register stages (1..4)
//   p_decr_amt - constant subtracted from each message
//
// Ports:
//   clk       - clock, all state updates on posedge
//   reset     - synchronous active-high reset
//   in_val    - upstream message valid
//   in_rdy    - block can accept a message this cycle
//   in_msg    - upstream message
//   out_val   - downstream message valid
//   out_rdy   - downstream can accept
//   out_msg   - decremented message (0 when out_val is low)
//   occupancy - number of messages currently held
//
// Optional feature:
//   REGDECR_VALRDY_PIPE_SAT_EN - when defined, the subtraction saturates
//   at zero instead of wrapping modulo 2^p_nbits.

module regdecr_valrdy_pipe #(
    parameter int p_nbits    = 8,
    parameter int p_nstages  = 2,
    parameter int p_decr_amt = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_val,
    output logic                             in_rdy,
    input  logic [p_nbits-1:0]               in_msg,
    output logic                             out_val,
    input  logic                             out_rdy,
    output logic [p_nbits-1:0]               out_msg,
    output logic [$clog2(p_nstages+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(p_nstages + 1);
    localparam logic [p_nbits-1:0] DECR    = p_nbits'(p_decr_amt);
    localparam logic [OCC_W-1:0]   OCC_ONE = OCC_W'(1);

    logic [p_nstages-1:0] stage_val;
    logic [p_nbits-1:0]   stage_data [p_nstages];

    // stage_rdy[k]: stage k may load this cycle because it is empty or its
    // content moves on. The last stage moves on out_rdy.
    logic [p_nstages-1:0] stage_rdy;

    // What each stage would load: the previous stage's content, or the
    // input port for stage 0.
    logic [p_nstages-1:0] nxt_val;
    logic [p_nbits-1:0]   nxt_data [p_nstages];

    logic                 in_fire;
    logic                 out_fire;
    logic [p_nbits-1:0]   last_data;

    // The ready chain runs backwards from out_rdy. A local running "go"
    // flag carries the chain, so the vector never reads its own bits.
    always_comb begin : ready_chain
        logic go;
        go        = out_rdy;
        stage_rdy = '0;
        for (int k = p_nstages - 1; k >= 0; k--) begin
            stage_rdy[k] = !stage_val[k] || go;
            go           = stage_rdy[k];
        end
    end

    // Forward feed: each stage looks at its predecessor, and stage 0 looks at
    // the input port.
    always_comb begin : feed_chain
        logic               prev_val;
        logic [p_nbits-1:0] prev_data;
        prev_val  = in_val;
        prev_data = in_msg;
        nxt_val   = '0;
        for (int k = 0; k < p_nstages; k++) begin
            nxt_val[k]  = prev_val;
            nxt_data[k] = prev_data;
            prev_val    = stage_val[k];
            prev_data   = stage_data[k];
        end
    end

    // Reset holds in_rdy low so nothing is accepted during the reset cycle.
    assign in_rdy    = !reset && stage_rdy[0];
    assign in_fire   = in_val && in_rdy;
    assign out_val   = stage_val[p_nstages-1];
    assign out_fire  = out_val && out_rdy;
    assign last_data = stage_data[p_nstages-1];

    // Stage registers. A stage that is ready takes whatever its feed offers.
    // When the feed is empty, the stage becomes empty too. Data is loaded
    // only alongside a valid message, so idle stages keep their old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_val <= '0;
            for (int k = 0; k < p_nstages; k++) begin
                stage_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < p_nstages; k++) begin
                if (stage_rdy[k]) begin
                    stage_val[k] <= nxt_val[k];
                    if (nxt_val[k]) begin
                        stage_data[k] <= nxt_data[k];
                    end
                end
            end
        end
    end

    // Occupancy counts handshakes rather than valid bits. It moves only when
    // exactly one side transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Output subtraction on the last stage. The output is forced to zero
    // while nothing is valid.
    always_comb begin
        out_msg = '0;
        if (out_val) begin
`ifdef REGDECR_VALRDY_PIPE_SAT_EN
            if (last_data < DECR) begin
                out_msg = '0;
            end else begin
                out_msg = last_data - DECR;
            end
`else
            out_msg = last_data - DECR;
`endif
        end
    end

endmodule

// File: tb/tb_regdecr_valrdy_pipe.sv
// tb_regdecr_valrdy_pipe
//
// Scoreboard bench for regdecr_valrdy_pipe. Each accepted message pushes its
// expected result and an age into a queue. A monitor runs on every negedge.
// It works out the expected in_rdy, occupancy, out_val and out_msg from the
// queue contents and compares them with the DUT.
//
// The model's view of the pipeline: the number of held messages is the
// queue length. The oldest message becomes visible once it has been inside
// for p_nstages-1 clock edges. Input is refused only when every slot is full
// and out_rdy is low.

module tb_regdecr_valrdy_pipe;

    localparam int NB   = 8;
    localparam int NST  = 2;
    localparam int DECR = 1;

    typedef struct {
        logic [NB-1:0] val;
        int            age;
    } item_t;

    logic          clk;
    logic          reset;
    logic          in_val;
    logic          in_rdy;
    logic [NB-1:0] in_msg;
    logic          out_val;
    logic          out_rdy;
    logic [NB-1:0] out_msg;
    logic [$clog2(NST+1)-1:0] occupancy;

    item_t         sb[$];
    int            tests;
    int            fails;
    int            acc_count;
    bit            loopback_mode;
    logic [NB-1:0] in_orig;
    bit            rst_prev;

    regdecr_valrdy_pipe #(
        .p_nbits   (NB),
        .p_nstages (NST),
        .p_decr_amt(DECR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_msg   (in_msg),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_msg  (out_msg),
        .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decrement written as plain integer arithmetic.
    function automatic logic [NB-1:0] refDecr(input logic [NB-1:0] x);
        int r;
        r = int'(x) - DECR;
        if (r < 0) begin
`ifdef REGDECR_VALRDY_PIPE_SAT_EN
            r = 0;
`else
            r = r + (1 << NB);
`endif
        end
        return NB'(r);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                     name, $time, act, exp);
        end
    endtask

    // Monitor and scoreboard. It compares first, then advances the model
    // across the coming posedge.
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("in_rdy_in_reset", {31'd0, in_rdy}, 32'd0);
            if (rst_prev) begin
                checkOutput("out_val_in_reset", {31'd0, out_val}, 32'd0);
                checkOutput("out_msg_in_reset", {24'd0, out_msg}, 32'd0);
                checkOutput("occupancy_in_reset", 32'(occupancy), 32'd0);
            end
            sb.delete();
            rst_prev = 1'b1;
        end else begin
            bit exp_rdy;
            bit exp_oval;
            exp_rdy  = (sb.size() < NST) || out_rdy;
            exp_oval = (sb.size() > 0) && (sb[0].age >= NST - 1);
            checkOutput("in_rdy", {31'd0, in_rdy}, {31'd0, exp_rdy});
            checkOutput("occupancy", 32'(occupancy), 32'(sb.size()));
            checkOutput("out_val", {31'd0, out_val}, {31'd0, exp_oval});
            if (exp_oval) begin
                checkOutput("out_msg", {24'd0, out_msg}, {24'd0, sb[0].val});
            end else begin
                checkOutput("out_msg_idle", {24'd0, out_msg}, 32'd0);
            end
            if (exp_oval && out_rdy) begin
                void'(sb.pop_front());
            end
            foreach (sb[i]) begin
                sb[i].age = sb[i].age + 1;
            end
            if (in_val && exp_rdy) begin
                item_t it;
                it.val = loopback_mode ? in_orig : refDecr(in_msg);
                it.age = 0;
                sb.push_back(it);
                acc_count++;
            end
            rst_prev = 1'b0;
        end
    end

    // Offer one message and hold it until the model reports that it was
    // accepted. The wait is bounded.
    task automatic applyStimulus(input logic [NB-1:0] v);
        int start;
        int waited;
        in_val = 1'b1;
        in_msg = v;
        start  = acc_count;
        waited = 0;
        do begin
            @(posedge clk);
            waited++;
        end while (acc_count == start && waited < 50);
        #1;
        in_val = 1'b0;
        if (acc_count == start) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: msg 0x%0h not accepted in %0d cycles",
                     v, waited);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        acc_count     = 0;
        loopback_mode = 1'b0;
        in_orig       = '0;
        rst_prev      = 1'b0;
        reset         = 1'b1;
        in_val        = 1'b0;
        in_msg        = '0;
        out_rdy       = 1'b1;

        // Basic single message after a two-cycle reset.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(8'h05);
        idleCycles(4);

        // Back-to-back stream at full throughput.
        applyStimulus(8'h10);
        applyStimulus(8'h11);
        applyStimulus(8'h12);
        applyStimulus(8'h13);
        idleCycles(4);

        // Backpressure: the third message waits until out_rdy rises.
        out_rdy = 1'b0;
        applyStimulus(8'h20);
        applyStimulus(8'h21);
        in_val = 1'b1;
        in_msg = 8'h22;
        idleCycles(3);
        out_rdy = 1'b1;
        applyStimulus(8'h22);
        idleCycles(4);

        // Wrap or saturate at zero, plus a stall on the wrapped value.
        applyStimulus(8'h00);
        out_rdy = 1'b0;
        applyStimulus(8'hFF);
        idleCycles(2);
        out_rdy = 1'b1;
        idleCycles(4);

        // Reset in the middle of a full, stalled pipeline.
        out_rdy = 1'b0;
        applyStimulus(8'h40);
        applyStimulus(8'h41);
        reset = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        out_rdy = 1'b1;
        idleCycles(4);

        // Loopback: model an incrementer upstream and expect the originals.
        loopback_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [NB-1:0] v;
`ifdef REGDECR_VALRDY_PIPE_SAT_EN
            v = NB'($urandom_range((1 << NB) - 1 - DECR, 0));
`else
            v = NB'($urandom_range((1 << NB) - 1, 0));
`endif
            in_orig = v;
            in_msg  = NB'(int'(v) + DECR);
            in_val  = ($urandom_range(3, 0) != 0);
            out_rdy = ($urandom_range(2, 0) != 0);
            @(posedge clk);
            #1;
        end
        in_val  = 1'b0;
        out_rdy = 1'b1;
        idleCycles(NST + 4);
        checkOutput("drained_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
